i2c_fmt_fifo: RTL

Format FIFO sitting directly upstream of the I2C host PHY integration stage. Software or a CSR front-end pushes 13-bit format entries (data byte plus five command flags); the block buffers them and presents the head entry, the valid flag and the fill level on the `fmt_*` handshake consumed by the host controller. It also flags overflow and low-watermark conditions, so firmware can refill before the bus transaction starves.

---
 rtl/i2c_fmt_fifo.sv | 72 +++++++
 1 files changed

// File: rtl/i2c_fmt_fifo.sv
// i2c_fmt_fifo: first-word-fall-through FIFO of 13-bit I2C format entries
// with fill level, overflow pulse and low-watermark flag.
module i2c_fmt_fifo #(
  parameter int FifoDepth = 64,
  localparam int FifoDepthWidth = $clog2(FifoDepth + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      fmt_wvalid_i,
  output logic                      fmt_wready_o,
  input  logic [12:0]               fmt_wdata_i,
  input  logic                      fmt_fifo_clr_i,
  input  logic [FifoDepthWidth-1:0] fmt_thresh_i,
  output logic                      fmt_fifo_rvalid_o,
  output logic [FifoDepthWidth-1:0] fmt_fifo_depth_o,
  input  logic                      fmt_fifo_rready_i,
  output logic [7:0]                fmt_byte_o,
  output logic                      fmt_flag_start_before_o,
  output logic                      fmt_flag_stop_after_o,
  output logic                      fmt_flag_read_bytes_o,
  output logic                      fmt_flag_read_continue_o,
  output logic                      fmt_flag_nak_ok_o,
  output logic                      event_fmt_overflow_o,
  output logic                      event_fmt_threshold_o
);
  localparam int PtrW = $clog2(FifoDepth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);
  logic [12:0] mem [FifoDepth];
  logic [PtrW-1:0] wptr, rptr;
  logic [FifoDepthWidth-1:0] cnt;
  logic full, empty, push, pop, ovf;
  logic [12:0] head;
  assign full  = cnt == FifoDepthWidth'(FifoDepth);
  assign empty = cnt == '0;
  assign push  = fmt_wvalid_i && !full;
  assign pop   = fmt_fifo_rready_i && !empty;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (fmt_fifo_clr_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
      if (pop) rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
      if (push && !pop) cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      ovf <= fmt_wvalid_i && full;
    end
  end
  // Storage is intentionally unreset; only pointers and count define contents.
  always_ff @(posedge clk_i) begin
    if (push && !fmt_fifo_clr_i) mem[wptr] <= fmt_wdata_i;
  end
  assign head = empty ? '0 : mem[rptr];
  assign fmt_wready_o             = !full;
  assign fmt_fifo_rvalid_o        = !empty;
  assign fmt_fifo_depth_o         = cnt;
  assign fmt_byte_o               = head[7:0];
  assign fmt_flag_start_before_o  = head[8];
  assign fmt_flag_stop_after_o    = head[9];
  assign fmt_flag_read_bytes_o    = head[10];
  assign fmt_flag_read_continue_o = head[11];
  assign fmt_flag_nak_ok_o        = head[12];
  assign event_fmt_overflow_o     = ovf;
  assign event_fmt_threshold_o    = cnt < fmt_thresh_i;
endmodule
